// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: multi-digit hex to 7-segment display controller.
// A single nibble decoder is time-multiplexed over the digits, MSB first,
// one digit per cycle after a load is accepted. Segment outputs are
// active-low with bit order g,f,e,d,c,b,a per digit. A free-running blink
// counter can blank the whole display during its off phase.
// Optional feature macro: HEX_DISP_LZB_EN (leading-zero blanking).
module hex_disp_ctrl #(
  parameter int DIGITS  = 4,
  parameter int BLINK_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  ready,
  output logic                  done,
  output logic [7*DIGITS-1:0]   segs
);

  // Digit index is at most 5, so three bits cover every legal DIGITS.
  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_DECODE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_idx;
  logic [4*DIGITS-1:0]   r_value;
  logic                  r_blank_lz;
  logic                  r_nz_seen;
  logic                  r_done;
  logic [7*DIGITS-1:0]   r_segs;
  logic [BLINK_W-1:0]    r_blink;

  logic [3:0]            w_nib;
  logic                  w_last;
  logic                  w_blank_digit;
  logic [6:0]            w_glyph;
  logic                  w_blink_off;

  // Active-low glyph for one hex nibble, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Select the shadow nibble addressed by the current digit index.
  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_nib = r_value[4*i +: 4];
      end
    end
  end

  assign w_last = (r_idx == 3'd0);

`ifdef HEX_DISP_LZB_EN
  // A zero digit is blanked while nothing above it in this update was
  // nonzero; the units digit always shows so zero reads as "0".
  assign w_blank_digit = r_blank_lz && !r_nz_seen && (w_nib == 4'd0) && !w_last;
`else
  // Blanking is compiled out; the shadow flags exist but drive nothing.
  logic w_unused_lz;
  assign w_unused_lz   = r_blank_lz | r_nz_seen;
  assign w_blank_digit = 1'b0;
`endif

  assign w_glyph = w_blank_digit ? SEG_OFF : hex_to_seg(w_nib);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and ready: one decode cycle per digit, then back to idle.
  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Shadow copy of the value; it only changes when a load is accepted,
  // so input changes mid-update cannot disturb the digits being written.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && load) begin
      r_value <= value;
    end
  end

  // Digit index, blanking flags, segment registers and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= LAST_IDX;
      r_blank_lz <= 1'b0;
      r_nz_seen  <= 1'b0;
      r_done     <= 1'b0;
      r_segs     <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_idx      <= LAST_IDX;
            r_blank_lz <= blank_lz;
            r_nz_seen  <= 1'b0;
          end
        end
        S_DECODE: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
              r_segs[7*i +: 7] <= w_glyph;
            end
          end
          if (w_nib != 4'd0) begin
            r_nz_seen <= 1'b1;
          end
          if (w_last) begin
            r_idx  <= LAST_IDX;
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx - 3'd1;
          end
        end
        default: begin
          r_idx <= LAST_IDX;
        end
      endcase
    end
  end

  // Free-running blink counter; its MSB selects the off phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  // Blinking masks the outputs only; stored patterns are untouched.
  assign w_blink_off = blink_en && r_blink[BLINK_W-1];
  assign segs        = w_blink_off ? '1 : r_segs;
  assign done        = r_done;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Testbench for hex_disp_ctrl (DIGITS=4, BLINK_W=4) with a behavioural
// display model; honours HEX_DISP_LZB_EN when it is defined for the build.
module tb_hex_disp_ctrl;

  localparam int DIGITS  = 4;
  localparam int BLINK_W = 4;

`ifdef HEX_DISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        ready;
  logic        done;
  logic [27:0] segs;

  int          checks = 0;
  int          errors = 0;
  int          cycles;
  logic [6:0]  glyph [16];
  logic [27:0] exp_disp;

  hex_disp_ctrl #(.DIGITS(DIGITS), .BLINK_W(BLINK_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .ready    (ready),
    .done     (done),
    .segs     (segs)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) cycles <= 0;
    else       cycles <= cycles + 1;
  end

  // Expected stored display for a completed update of v.
  function automatic logic [27:0] model_segs(input logic [15:0] v, input logic lz);
    logic [27:0] r;
    logic [3:0]  nib;
    int          hi;
    r = '1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = 4'((v >> (4*i)) & 16'hF);
      hi  = int'(v >> (4*i));
      if (LZB && lz && i != 0 && hi == 0) r[7*i +: 7] = 7'b1111111;
      else                                r[7*i +: 7] = glyph[nib];
    end
    return r;
  endfunction

  function automatic logic blink_off_now();
    return blink_en && ((cycles % (1 << BLINK_W)) >= (1 << (BLINK_W-1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one load and observe ready/done over the following samples.
  task automatic run_load(input logic [15:0] v, input logic lz,
                          output int rlow, output int dcnt, output int dat);
    value = v; blank_lz = lz; load = 1'b1;
    step();
    load = 1'b0;
    rlow = 0; dcnt = 0; dat = -1;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) step();
      if (!ready) rlow++;
      if (done) begin dcnt++; dat = n; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (segs !== 28'hFFFFFFF) begin errors++; $display("FAIL reset_segs got %h want %h", segs, 28'hFFFFFFF); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    exp_disp = '1;
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", ready); end
  endtask

  task automatic test_known();
    int rlow, dcnt, dat;
    logic [27:0] want;
    want = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
    run_load(16'h12AF, 1'b0, rlow, dcnt, dat);
    checks++; if (segs !== want) begin errors++; $display("FAIL known_segs got %h want %h", segs, want); end
    checks++; if (rlow != 4) begin errors++; $display("FAIL known_ready_low got %0d want 4", rlow); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL known_done_count got %0d want 1", dcnt); end
    checks++; if (dat != 4) begin errors++; $display("FAIL known_done_at got %0d want 4", dat); end
    exp_disp = want;
  endtask

  task automatic test_ignore_busy();
    int rlow, dcnt;
    logic [27:0] want;
    want = model_segs(16'h1234, 1'b0);
    value = 16'h1234; blank_lz = 1'b0; load = 1'b1;
    step();
    rlow = 0; dcnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) step();
      if (!ready) rlow++;
      if (done) dcnt++;
      if (n < 3) begin load = 1'b1; value = 16'hFFFF; end
      else load = 1'b0;
    end
    checks++; if (segs !== want) begin errors++; $display("FAIL busy_segs got %h want %h", segs, want); end
    checks++; if (rlow != 4) begin errors++; $display("FAIL busy_ready_low got %0d want 4", rlow); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dcnt); end
    exp_disp = want;
  endtask

  task automatic test_lzb();
    int rlow, dcnt, dat;
    logic [27:0] w70, w00;
`ifdef HEX_DISP_LZB_EN
    w70 = {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000};
    w00 = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
`else
    w70 = {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000};
    w00 = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
    run_load(16'h0070, 1'b1, rlow, dcnt, dat);
    checks++; if (segs !== w70) begin errors++; $display("FAIL lzb_0070 got %h want %h", segs, w70); end
    run_load(16'h0000, 1'b1, rlow, dcnt, dat);
    checks++; if (segs !== w00) begin errors++; $display("FAIL lzb_0000 got %h want %h", segs, w00); end
    run_load(16'h0070, 1'b0, rlow, dcnt, dat);
    checks++; if (segs !== {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}) begin
      errors++; $display("FAIL lzb_off_0070 got %h want %h", segs, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}); end
    run_load(16'h0305, 1'b1, rlow, dcnt, dat);
    checks++; if (segs !== model_segs(16'h0305, 1'b1)) begin
      errors++; $display("FAIL lzb_0305 got %h want %h", segs, model_segs(16'h0305, 1'b1)); end
    exp_disp = model_segs(16'h0305, 1'b1);
  endtask

  task automatic test_random();
    int rlow, dcnt, dat;
    logic [15:0] v;
    logic        lz;
    for (int t = 0; t < 24; t++) begin
      v  = 16'($urandom) >> $urandom_range(0, 16);
      lz = 1'($urandom_range(0, 1));
      run_load(v, lz, rlow, dcnt, dat);
      checks++; if (segs !== model_segs(v, lz)) begin
        errors++; $display("FAIL rand_segs v=%h lz=%b got %h want %h", v, lz, segs, model_segs(v, lz)); end
      checks++; if (dcnt != 1 || dat != 4 || rlow != 4) begin
        errors++; $display("FAIL rand_timing v=%h got done=%0d at %0d rlow=%0d want 1 at 4 rlow=4", v, dcnt, dat, rlow); end
      exp_disp = model_segs(v, lz);
    end
  endtask

  task automatic test_reset_mid_decode();
    value = 16'hABCD; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", ready); end
    reset = 1'b1;
    #1;
    checks++; if (segs !== 28'hFFFFFFF) begin errors++; $display("FAIL mid_reset_segs got %h want %h", segs, 28'hFFFFFFF); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got %b want 0", done); end
    step(); step();
    reset = 1'b0;
    exp_disp = '1;
    step();
    checks++; if (segs !== 28'hFFFFFFF || ready !== 1'b1) begin
      errors++; $display("FAIL after_reset got segs=%h ready=%b want %h 1", segs, ready, 28'hFFFFFFF); end
  endtask

  task automatic test_blink();
    int rlow, dcnt, dat;
    logic [27:0] want;
    run_load(16'h5555, 1'b0, rlow, dcnt, dat);
    exp_disp = {4{7'b0010010}};
    checks++; if (segs !== exp_disp) begin errors++; $display("FAIL blink_load got %h want %h", segs, exp_disp); end
    blink_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      want = blink_off_now() ? 28'hFFFFFFF : exp_disp;
      checks++; if (segs !== want || ready !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL blink_cycle %0d got segs=%h ready=%b done=%b want %h 1 0", n, segs, ready, done, want); end
    end
    blink_en = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      checks++; if (segs !== exp_disp) begin errors++; $display("FAIL blink_off_steady got %h want %h", segs, exp_disp); end
    end
  endtask

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_known();
    test_ignore_busy();
    test_lzb();
    test_random();
    test_reset_mid_decode();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_disp_ctrl.md
HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of hex digits driven; legal range 1..6.
REQ-002 Parameter BLINK_W, default 24, meaning width of the free-running blink counter.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port load  input  1  request to capture value; honoured only while ready=1.
REQ-006 Port value  input  4*DIGITS  hex value to display; nibble i drives digit i, digit 0 = LSB.
REQ-007 Port blank_lz  input  1  leading-zero blanking request, sampled with load.
REQ-008 Port blink_en  input  1  when 1, blanks all digits during the off phase of the blink counter.
REQ-009 Port ready  output  1  high when idle and able to accept load.
REQ-010 Port done  output  1  one-cycle pulse when a full display update completes.
REQ-011 Port segs  output  7*DIGITS  active-low segment bus; bits [7i+6:7i] drive digit i, bit order g,f,e,d,c,b,a (bit 6 = middle).

Function
REQ-012 The block SHALL use exactly one nibble-to-segment decoder, time-multiplexed across digits.
REQ-013 The FSM SHALL have states IDLE and DECODE; ready SHALL equal (state==IDLE).
REQ-014 In IDLE with load=1 at a rising edge, the block SHALL latch value and blank_lz into shadow registers, set idx=DIGITS-1, clear the nonzero-seen flag, and enter DECODE.
REQ-015 In IDLE with load=0, the block SHALL hold state; segs SHALL keep the last decoded pattern.
REQ-016 Each DECODE cycle SHALL decode shadow nibble idx into the digit-idx segment register, then decrement idx (MSB first).
REQ-017 On the edge writing digit 0, the FSM SHALL return to IDLE and done SHALL be 1 for exactly that following cycle.
REQ-018 Latency: load accepted at edge k -> all DIGITS digits updated and done=1 after edge k+DIGITS.
REQ-019 load while ready=0 SHALL be ignored; value changes during DECODE SHALL NOT affect the update in progress.
REQ-020 Encodings 0-F SHALL be 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000,0001000,0000011,1000110,0100001,0000110,0001110; blank = 1111111.
REQ-021 A free-running BLINK_W-bit counter SHALL increment every cycle and wrap from all-ones to zero.
REQ-022 When blink_en=1 and the counter MSB=1, segs SHALL be all 1s; the stored pattern SHALL be unaffected and reappear when the MSB returns to 0 or blink_en=0.
REQ-023 blink_en SHALL act combinationally on segs and SHALL NOT affect ready, done or the FSM.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, idx=DIGITS-1, done=0, blink counter=0 and all segment registers to 1111111 (all off), including mid-DECODE.
REQ-025 After reset deassertion, ready SHALL be 1 and the first load SHALL be accepted on the next rising edge.

Configuration
REQ-026 Macro HEX_DISP_LZB_EN SHALL compile the leading-zero-blanking logic in or out.
REQ-027 With HEX_DISP_LZB_EN defined and shadow blank_lz=1, a digit whose nibble is 0 and for which no higher digit in this update was nonzero SHALL decode to blank; digit 0 SHALL never be blanked.
REQ-028 Without HEX_DISP_LZB_EN, the blank_lz port SHALL remain present but be ignored, and every digit SHALL show its hex glyph.

Verification
REQ-029 Assert reset mid-DECODE -> segs all 1s, ready=1, done=0 immediately; counter reads 0 after release.
REQ-030 DIGITS=4, load value=0x12AF -> after 4 edges done pulses once; digits 3..0 = 1111001,0100100,0001000,0001110; ready low for exactly 4 cycles.
REQ-031 Load 0x1234, change value to 0xFFFF and pulse load during DECODE -> display ends at 0x1234; second load ignored; one done pulse.
REQ-032 HEX_DISP_LZB_EN defined, blank_lz=1, load 0x0070 -> digits 3,2 = 1111111, digit 1 = 1111000, digit 0 = 1000000; load 0x0000 -> only digit 0 lit with 1000000.
REQ-033 BLINK_W=4, blink_en=1 after loading 0x5555 -> segs alternate 8 cycles 0010010 per digit / 8 cycles all 1s; blink_en=0 -> steady 0010010.
REQ-034 HEX_DISP_LZB_EN undefined, blank_lz=1, load 0x0070 -> digits 3..0 = 1000000,1000000,1111000,1000000.
